fs_1bit_sub: RTL and testbench
==============================

# fs_1bit_sub

Clocked 1-bit full subtractor (A − B − borrow-in) used as the bit-slice primitive of the ALU subtract path. It can work as an isolated full subtractor or as a bit-serial subtractor: words are presented LSB first and the borrow is chained internally between beats. It provides registered outputs for the pipeline plus combinational outputs for ripple use.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active low
- A  in  1  minuend bit
- B  in  1  subtrahend bit
- Bin  in  1  external borrow-in; used only on a start-of-word beat
- in_valid  in  1  beat qualifier; A/B/Bin/sof are sampled only when high
- sof  in  1  start of word; selects Bin instead of the stored borrow
- Diff_c  out  1  combinational difference for the current inputs
- Bout_c  out  1  combinational borrow-out for the current inputs
- Diff  out  1  registered difference
- Bout  out  1  registered borrow-out
- out_valid  out  1  registered; high for one cycle per accepted beat

## Operation
- Effective borrow-in: bin_eff = sof ? Bin : borrow_q.
- Diff_c = A ^ B ^ bin_eff.
- Bout_c = (~A & B) | (~(A ^ B) & bin_eff).
- Arithmetic identity: A − B − bin_eff = Diff_c − 2·Bout_c. All values are 1 bit, and there is no other width rule.
- When in_valid=1 at a clock edge:
  - Diff ← Diff_c
  - Bout ← Bout_c
  - borrow_q ← Bout_c
  - out_valid ← 1
- When in_valid=0 at a clock edge:
  - Diff and Bout hold their values.
  - borrow_q holds, so a serial word may stall for any number of cycles without losing the chain.
  - out_valid ← 0.
- Combinational outputs follow the inputs at all times, independent of in_valid. While sof=0 they depend on borrow_q.
- A serial N-bit word is a beat with sof=1 (Bin = word borrow-in), then N−1 beats with sof=0. The final word borrow is Bout on the last beat.
- Modulo result: on wrap-around (B + Bin > A for the word), the result is the two's-complement residue and the final Bout is 1.
- A sof=1 beat may arrive at any time. It discards the current borrow_q and starts a new word; no error is flagged.
- Internal state is borrow_q only. There is no FSM beyond this chain flop.

## Timing
- Reset (rst_n=0, asynchronous): Diff=0, Bout=0, out_valid=0, borrow_q=0, all immediately and without a clock.
- Release of rst_n is synchronous in effect: the first beat can be accepted on the first rising edge after rst_n goes high.
- Reset mid-word clears borrow_q. The next beat with sof=0 then uses borrow 0.
- Registered-output latency: one cycle. A beat accepted at edge k appears on Diff/Bout with out_valid=1 after edge k. It stays there until the next accepted beat or reset.
- Combinational outputs have zero cycles of latency.
- Throughput: one beat per cycle and back-to-back in_valid are supported. There is no backpressure input.

## Test plan
- **Exhaustive truth table:** all 8 {A,B,Bin}, each with sof=1, in_valid=1, back to back.
  - Required (Diff,Bout) for 000,100,010,110,001,101,011,111: 00,10,11,00,11,00,01,11.
  - Registered values appear one cycle after combinational.
- **Serial 5−3:**
  - Stimulus: A=0101, B=0011 LSB first, Bin=0, sof on the first beat.
  - Required: Diff stream 0,1,0,0 (=0010); final Bout=0; out_valid high for 4 cycles.
- **Serial wrap 3−5:**
  - Stimulus: A=0011, B=0101.
  - Required: Diff=1110, final Bout=1.
- **Stall:**
  - Stimulus: same as 5−3, with in_valid=0 for 3 cycles between beats 1 and 2.
  - Required: identical Diff stream; out_valid low during the gap; Diff/Bout held.
- **Reset mid-word:**
  - Stimulus: beat A=0,B=1,sof=1 (borrow_q=1), then rst_n pulsed low between edges.
  - Required: Diff/Bout/out_valid go 0 immediately. The next beat A=1,B=0,sof=0 gives Diff=1, Bout=0.
- **sof mid-word:**
  - Stimulus: with borrow_q=1, apply A=1,B=0,Bin=0,sof=1.
  - Required: Diff=1, Bout=0 (stored borrow ignored).

Source files
------------

// File: rtl/fs_1bit_sub.sv
// Clocked 1-bit full subtractor (A - B - borrow) usable stand-alone or as a
// bit-serial subtractor with the borrow chained internally, LSB first.
module fs_1bit_sub (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic Bin,
    input  logic in_valid,
    input  logic sof,
    output logic Diff_c,
    output logic Bout_c,
    output logic Diff,
    output logic Bout,
    output logic out_valid
);

    logic r_borrow;
    logic r_diff;
    logic r_bout;
    logic r_out_valid;

    logic w_bin_eff;
    logic w_diff;
    logic w_bout;

    // A start-of-word beat takes the external borrow; otherwise continue the chain.
    assign w_bin_eff = sof ? Bin : r_borrow;
    assign w_diff    = A ^ B ^ w_bin_eff;
    assign w_bout    = (~A & B) | (~(A ^ B) & w_bin_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_borrow    <= 1'b0;
            r_diff      <= 1'b0;
            r_bout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            // Idle cycles hold both outputs and the chain so a word may stall.
            if (in_valid) begin
                r_borrow <= w_bout;
                r_diff   <= w_diff;
                r_bout   <= w_bout;
            end
        end
    end

    assign Diff_c    = w_diff;
    assign Bout_c    = w_bout;
    assign Diff      = r_diff;
    assign Bout      = r_bout;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_fs_1bit_sub.sv
// Directed self-checking bench for fs_1bit_sub: truth table, serial words,
// stalls, asynchronous reset mid-word and restart on sof mid-word.
module tb_fs_1bit_sub;

    logic clk;
    logic rst_n;
    logic A, B, Bin, in_valid, sof;
    logic Diff_c, Bout_c, Diff, Bout, out_valid;

    int n_checks;
    int n_errors;

    fs_1bit_sub dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .in_valid  (in_valid),
        .sof       (sof),
        .Diff_c    (Diff_c),
        .Bout_c    (Bout_c),
        .Diff      (Diff),
        .Bout      (Bout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Drives one accepted beat: checks combinational outputs first, then the
    // registered outputs one edge later.
    task automatic beat(input string tag, input logic a, input logic b, input logic bin,
                        input logic s, input logic exp_d, input logic exp_bo);
        A = a; B = b; Bin = bin; sof = s; in_valid = 1'b1;
        #1;
        chk({tag, " Diff_c"}, Diff_c, exp_d);
        chk({tag, " Bout_c"}, Bout_c, exp_bo);
        @(posedge clk);
        #1;
        chk({tag, " Diff"}, Diff, exp_d);
        chk({tag, " Bout"}, Bout, exp_bo);
        chk({tag, " out_valid"}, out_valid, 1'b1);
        $display("beat %s A=%b B=%b Bin=%b sof=%b -> Diff=%b Bout=%b", tag, a, b, bin, s, Diff, Bout);
    endtask

    // One idle cycle with noisy data inputs; registered outputs must hold.
    task automatic idle(input string tag, input logic hold_d, input logic hold_bo);
        in_valid = 1'b0;
        A = 1'($urandom); B = 1'($urandom); Bin = 1'($urandom); sof = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " idle out_valid"}, out_valid, 1'b0);
        chk({tag, " idle Diff"}, Diff, hold_d);
        chk({tag, " idle Bout"}, Bout, hold_bo);
        $display("idle %s -> Diff=%b Bout=%b out_valid=%b", tag, Diff, Bout, out_valid);
    endtask

    // 4-bit serial word, LSB first; optional stall after beat stall_at.
    task automatic serial_word(input string tag, input logic [3:0] a, input logic [3:0] b,
                               input logic bin, input logic [3:0] exp_d,
                               input logic [3:0] exp_bo, input int stall_at,
                               input int stall_len);
        for (int i = 0; i < 4; i++) begin
            beat($sformatf("%s[%0d]", tag, i), a[i], b[i], bin, (i == 0), exp_d[i], exp_bo[i]);
            if (i == stall_at)
                for (int k = 0; k < stall_len; k++)
                    idle($sformatf("%s gap%0d", tag, k), exp_d[i], exp_bo[i]);
        end
        idle({tag, " end"}, exp_d[3], exp_bo[3]);
    endtask

    logic [2:0] tt_in  [8] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
    logic [1:0] tt_exp [8] = '{2'b00, 2'b10, 2'b11, 2'b00, 2'b11, 2'b00, 2'b01, 2'b11};

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        A = 1'b0; B = 1'b0; Bin = 1'b0; in_valid = 1'b0; sof = 1'b0;
        #2;
        chk("reset Diff", Diff, 1'b0);
        chk("reset Bout", Bout, 1'b0);
        chk("reset out_valid", out_valid, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Exhaustive truth table, sof=1 back to back ({A,B,Bin} -> {Diff,Bout}).
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] e;
            v = tt_in[i];
            e = tt_exp[i];
            beat($sformatf("tt%b", v), v[2], v[1], v[0], 1'b1, e[1], e[0]);
        end
        idle("tt end", 1'b1, 1'b1);

        // 5 - 3 = 2 : A=0101 B=0011
        serial_word("5-3", 4'b0101, 4'b0011, 1'b0, 4'b0010, 4'b0010, -1, 0);
        // 3 - 5 wraps: Diff=1110, final Bout=1
        serial_word("3-5", 4'b0011, 4'b0101, 1'b0, 4'b1110, 4'b1100, -1, 0);
        // 5 - 3 with a 3-cycle stall between beats 1 and 2 (borrow 1 in flight)
        serial_word("5-3stall", 4'b0101, 4'b0011, 1'b0, 4'b0010, 4'b0010, 1, 3);

        // Reset mid-word: borrow 1 stored, then asynchronous reset between edges.
        beat("rst pre", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst mid Diff", Diff, 1'b0);
        chk("rst mid Bout", Bout, 1'b0);
        chk("rst mid out_valid", out_valid, 1'b0);
        $display("reset mid-word -> Diff=%b Bout=%b out_valid=%b", Diff, Bout, out_valid);
        #1;
        rst_n = 1'b1;
        beat("rst post", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // sof mid-word: stored borrow 1 must be ignored in favour of Bin=0.
        beat("sof pre", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        beat("sof mid", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        // Same inputs with sof=0 after a borrow 1: 1-0-1 gives Diff=0 Bout=0.
        beat("chain pre", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        beat("chain use", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle("final", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
